// File: rtl/display_pkg.sv
// Shared constants, converter state type and the add-3 helper for the display front end.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 16;
    localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_e;

    // Adds 3 to every BCD nibble that is 5 or more, all nibbles in parallel.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, 14 steps per value.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] value,
    output logic             ready,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Next-state logic: capture a clamped value in IDLE, then run one dabble step per cycle.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        shifted = {add3_all(acc_q), bin_q} << 1;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = (value > MAX_VALUE) ? MAX_VALUE : value;
                    acc_d   = '0;
                    cnt_d   = 4'd13;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = shifted;
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The finished result is the accumulator after the final shift, valid while done is high.
    assign bcd   = shifted[BCD_W+BIN_W-1:BIN_W];
    assign ready = (state_q == IDLE);

    // Converter state registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display: converts a loaded value to BCD and scans it onto digit/an.
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] value,
    output logic             ready,
    output logic [3:0]       digit,
    output logic [3:0]       an
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       digit_q, digit_d;
    logic [BCD_W-1:0] upper;
    logic             blank;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (value),
        .ready (ready),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Free-running prescaler; each wrap advances the scan slot.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // The display register only takes complete conversion results.
    always_comb begin
        disp_d = disp_q;
        if (conv_done) begin
            disp_d = conv_bcd;
        end
    end

    // Selects the current nibble and anode, blanking leading zeros above the ones digit.
    always_comb begin
        digit_d = disp_q[{idx_q, 2'b00} +: 4];
        upper   = disp_q >> {idx_q, 2'b00};
        blank   = (idx_q != 2'd0) && (upper == '0);
        an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    // Scanner, display and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            an_q    <= 4'b1110;
            digit_q <= 4'h0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    assign an    = an_q;
    assign digit = digit_q;

endmodule
